// File: rtl/rf_write_scheduler.sv
// Arbitrates the single register-file write port between pipeline writeback and
// the buffered MUL/DIV results, and tracks pending MDU destinations for hazard stalls.
module rf_write_scheduler #(
   parameter int DATA_W     = 64,
   parameter int ADDR_W     = 5,
   parameter int FIFO_DEPTH = 2,
   parameter int STARVE_LIM = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wb_we,
   input  logic [ADDR_W-1:0] wb_wa,
   input  logic [DATA_W-1:0] wb_wd,
   input  logic              mdu_valid,
   input  logic [ADDR_W-1:0] mdu_wa,
   input  logic [DATA_W-1:0] mdu_wd,
   output logic              mdu_ready,
   input  logic              iss_valid,
   input  logic [ADDR_W-1:0] iss_wa,
   output logic              iss_stall,
   input  logic [ADDR_W-1:0] chk_ra1,
   input  logic [ADDR_W-1:0] chk_ra2,
   output logic              rd_stall,
   output logic              mdu_starve,
   output logic              we3,
   output logic [ADDR_W-1:0] wa3,
   output logic [DATA_W-1:0] wd3
);

   localparam int NREG  = 1 << ADDR_W;
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int STV_W = $clog2(STARVE_LIM + 1);

   localparam logic [ADDR_W-1:0] XZR      = ADDR_W'(31);
   localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(FIFO_DEPTH);
   localparam logic [STV_W-1:0]  STARVE_C = STV_W'(STARVE_LIM);

   typedef struct packed {
      logic [ADDR_W-1:0] wa;
      logic [DATA_W-1:0] wd;
   } wr_req_t;

   wr_req_t           fifo_q [FIFO_DEPTH];
   wr_req_t           head;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [NREG-1:0]   pending_q, pending_d;
   logic [STV_W-1:0]  starve_q, starve_d;
   logic              we3_q, we3_d;
   logic [ADDR_W-1:0] wa3_q, wa3_d;
   logic [DATA_W-1:0] wd3_q, wd3_d;

   logic wb_sel;
   logic fifo_empty;
   logic push;
   logic pop;
   logic iss_ok;

   assign head       = fifo_q[rd_ptr_q];
   assign fifo_empty = (count_q == '0);
   assign mdu_ready  = (count_q < DEPTH_C);

   // Writeback to XZR is a no-op and must not steal the port from a FIFO pop.
   assign wb_sel = wb_we & (wb_wa != XZR);
   assign pop    = ~wb_sel & ~fifo_empty;
   assign push   = mdu_valid & mdu_ready & (mdu_wa != XZR);

   assign iss_stall  = iss_valid & pending_q[iss_wa];
   assign iss_ok     = iss_valid & ~pending_q[iss_wa] & (iss_wa != XZR);
   assign rd_stall   = (pending_q[chk_ra1] & (chk_ra1 != XZR)) |
                       (pending_q[chk_ra2] & (chk_ra2 != XZR));
   assign mdu_starve = (starve_q >= STARVE_C);

   assign we3 = we3_q;
   assign wa3 = wa3_q;
   assign wd3 = wd3_q;

   // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latch).
   always_comb begin
      we3_d = 1'b0;
      wa3_d = wa3_q;
      wd3_d = wd3_q;
      if (wb_sel) begin
         we3_d = 1'b1;
         wa3_d = wb_wa;
         wd3_d = wb_wd;
      end else if (pop) begin
         we3_d = 1'b1;
         wa3_d = head.wa;
         wd3_d = head.wd;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   // The issue set is applied after the pop clear so a same-cycle set wins.
   always_comb begin
      pending_d = pending_q;
      if (pop) begin
         pending_d[head.wa] = 1'b0;
      end
      if (iss_ok) begin
         pending_d[iss_wa] = 1'b1;
      end
      pending_d[XZR] = 1'b0;
   end

   always_comb begin
      starve_d = starve_q;
      if (fifo_empty || pop) begin
         starve_d = '0;
      end else if (starve_q < STARVE_C) begin
         starve_d = starve_q + 1'b1;
      end
   end

   // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         pending_q <= '0;
         starve_q  <= '0;
         we3_q     <= 1'b0;
         wa3_q     <= '0;
         wd3_q     <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         pending_q <= pending_d;
         starve_q  <= starve_d;
         we3_q     <= we3_d;
         wa3_q     <= wa3_d;
         wd3_q     <= wd3_d;
      end
   end

   // NOTE: buffer storage has no reset; the count makes stale entries unreachable.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_q[wr_ptr_q] <= wr_req_t'{wa: mdu_wa, wd: mdu_wd};
      end
   end

endmodule

// File: doc/rf_write_scheduler.md
Name: rf_write_scheduler

Overview:
- Schedules the single register-file write port (we3/wa3/wd3) between two requesters:
  - the in-order pipeline writeback, which cannot stall;
  - the multi-cycle MUL/DIV unit (MDU), which is valid/ready handshaked and buffered in a small FIFO.
- Holds a 32-entry pending-write scoreboard for MDU destinations and raises stall flags for decode-stage readers.
- Sits between the writeback stage, the MDU and regfile. X31 (XZR) is never written and never pending.

Parameters:
DATA_W, 64, register data width
ADDR_W, 5, register address width
FIFO_DEPTH, 2, MDU write buffer entries (power of two, >=2)
STARVE_LIM, 8, cycles a FIFO head may wait before mdu_starve asserts

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
wb_we  in  1  pipeline writeback write enable
wb_wa  in  ADDR_W  pipeline writeback register
wb_wd  in  DATA_W  pipeline writeback data
mdu_valid  in  1  MDU result valid
mdu_wa  in  ADDR_W  MDU destination register
mdu_wd  in  DATA_W  MDU result data
mdu_ready  out  1  FIFO can accept an MDU result
iss_valid  in  1  MDU op issuing this cycle
iss_wa  in  ADDR_W  destination of issuing MDU op
iss_stall  out  1  issue blocked (WAW on pending register)
chk_ra1  in  ADDR_W  decode source register 1
chk_ra2  in  ADDR_W  decode source register 2
rd_stall  out  1  a decode source has a pending MDU write
mdu_starve  out  1  FIFO head has waited >= STARVE_LIM cycles
we3  out  1  regfile write enable (registered)
wa3  out  ADDR_W  regfile write address (registered)
wd3  out  DATA_W  regfile write data (registered)

Behaviour:
- Reset (asynchronous, immediate) clears:
  - we3, wa3, wd3 to 0;
  - FIFO (count 0, pointers 0);
  - pending vector to 0;
  - starve counter to 0.
- During and after reset: mdu_ready=1, iss_stall=0, rd_stall=0, mdu_starve=0.
- Write-port selection, evaluated each cycle and registered into we3/wa3/wd3 at the next posedge (latency 1):
  - Case 1: wb_we=1 and wb_wa!=31 → load wb_wa/wb_wd, we3<=1. Writeback has absolute priority.
  - Case 2: otherwise, FIFO non-empty → pop head, load its wa/wd, we3<=1.
  - Case 3: otherwise → we3<=0. wa3/wd3 hold their previous values.
- wb_we=1 with wb_wa=31 is a no-op. It does not block a FIFO pop that cycle.
- FIFO push and accept:
  - mdu_ready = (count < FIFO_DEPTH), combinational from registered count only.
  - Push occurs on mdu_valid & mdu_ready.
  - mdu_wa=31 is accepted but not pushed (dropped).
- Same-cycle push and pop is legal whenever mdu_ready=1; count is unchanged.
- Pointers wrap modulo FIFO_DEPTH. Order is strictly FIFO.
- Scoreboard (pending[31:0], bit 31 tied 0):
  - Set pending[iss_wa] on iss_valid & !iss_stall & iss_wa!=31.
  - Clear pending[wa] on the edge that pops that entry into the write-port register. The bit is therefore already 0 while we3 is high, and regfile's internal bypass supplies the value.
  - Same-cycle set and clear of the same bit: set wins.
- iss_stall = iss_valid & pending[iss_wa] (combinational). A stalled issue does not modify pending.
- rd_stall = (pending[chk_ra1] & chk_ra1!=31) | (pending[chk_ra2] & chk_ra2!=31), combinational.
- Writeback-writes to a pending register do not clear its bit. MDU result ordering governs.
- Starve counter:
  - Increments, saturating at STARVE_LIM, each cycle the FIFO is non-empty and not popped.
  - Resets to 0 on pop or when the FIFO is empty.
  - mdu_starve = (counter >= STARVE_LIM).
- Reset mid-operation discards buffered results and pending bits. No write reaches regfile after reset asserts.

Test Plan:
- Reset, then wb_we=1, wb_wa=5, wb_wd=0xAA for one cycle → next cycle we3=1, wa3=5, wd3=0xAA; following cycle we3=0.
- Issue iss_wa=7, then chk_ra1=7 → rd_stall=1. MDU returns wa=7, wd=0x1234 with wb idle → FIFO pops, we3=1/wa3=7/wd3=0x1234, rd_stall=0 in the same cycle.
- Hold wb_we=1 (wa=3) for 10 cycles while pushing two MDU results (wa=8, 9):
  - mdu_ready drops to 0 after the 2nd push;
  - mdu_starve=1 from cycle 8 of waiting;
  - releasing wb → writes 8 then 9 on consecutive cycles, mdu_starve=0.
- MDU result to wa=31 and wb write to wa=31 → we3 stays 0; the FIFO count does not increase.
- iss_wa=4 pending, second iss_valid with iss_wa=4 → iss_stall=1, pending unchanged. Same-cycle pop of wa=4 with new issue to 4 → pending[4] remains 1.
- Push 2 results, assert reset mid-drain → we3=0 immediately, mdu_ready=1, rd_stall=0; no further writes appear.
